// File: rtl/stream_mux_arb_if.sv
// stream_mux_arb_if: NUM_IN valid/ready input streams muxed onto one registered output stream
interface stream_mux_arb_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_sel;
    modport slave  (input  in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_sel);
    modport master (output in_data, in_valid, out_ready, input  in_ready, out_data, out_valid, out_sel);
endinterface

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: fixed-priority or round-robin NUM_IN:1 stream mux with a registered output stage
module stream_mux_arb #(
    parameter int WIDTH   = 16,
    parameter int NUM_IN  = 4,
    parameter int RR_MODE = 1
) (
    input logic             clk,
    input logic             rst_n,
    stream_mux_arb_if.slave bus
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    logic [SEL_W-1:0]  ptr, win, out_sel_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_valid_q, found, load_en;
    logic [NUM_IN-1:0] grant;
    function automatic int cand(int k);
        return (RR_MODE != 0) ? (int'(ptr) + k) % NUM_IN : k;
    endfunction
    always_comb begin
        found = 1'b0;
        win = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!found && bus.in_valid[cand(k)]) begin
                found = 1'b1;
                win = SEL_W'(cand(k));
            end
        end
    end
    assign grant        = found ? (NUM_IN'(1) << win) : '0;
    assign load_en      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = grant & {NUM_IN{load_en}};
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
    // A load with no winner empties the stage but keeps the last data/index visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr         <= '0;
        end else if (load_en) begin
            out_valid_q <= found;
            if (found) begin
                out_data_q <= bus.in_data[int'(win)*WIDTH +: WIDTH];
                out_sel_q  <= win;
                ptr        <= (win == SEL_W'(NUM_IN - 1)) ? '0 : win + SEL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed checks of round-robin, fixed-priority and 3-input variants
module tb_stream_mux_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    stream_mux_arb_if #(.WIDTH(16), .NUM_IN(4)) a ();
    stream_mux_arb_if #(.WIDTH(16), .NUM_IN(4)) b ();
    stream_mux_arb_if #(.WIDTH(16), .NUM_IN(3)) c ();
    stream_mux_arb #(.WIDTH(16), .NUM_IN(4), .RR_MODE(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(a));
    stream_mux_arb #(.WIDTH(16), .NUM_IN(4), .RR_MODE(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(b));
    stream_mux_arb #(.WIDTH(16), .NUM_IN(3), .RR_MODE(1)) u_n3 (.clk(clk), .rst_n(rst_n), .bus(c));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        a.in_data = '0; a.in_valid = '0; a.out_ready = 1'b0;
        b.in_data = '0; b.in_valid = '0; b.out_ready = 1'b0;
        c.in_data = '0; c.in_valid = '0; c.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_valid", 32'(a.out_valid), 0);
        check("rst_data", 32'(a.out_data), 0);
        check("rst_sel", 32'(a.out_sel), 0);
        a.in_valid = 4'b0100;
        a.in_data  = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        a.out_ready = 1'b1;
        #1;
        check("single_ready", 32'(a.in_ready), 32'h4);
        step();
        check("single_valid", 32'(a.out_valid), 1);
        check("single_data", 32'(a.out_data), 32'hBEEF);
        check("single_sel", 32'(a.out_sel), 2);
        a.in_valid = '0;
        a.out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(a.out_valid), 0);
        check("async_rst_data", 32'(a.out_data), 0);
        check("async_rst_sel", 32'(a.out_sel), 0);
        step();
        rst_n = 1'b1;
        a.in_data  = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        a.in_valid = 4'b1111;
        a.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("rr_valid%0d", i), 32'(a.out_valid), 1);
            check($sformatf("rr_sel%0d", i), 32'(a.out_sel), 32'(i % 4));
            check($sformatf("rr_data%0d", i), 32'(a.out_data), 32'((i % 4 + 1) * 16'h11));
        end
        a.in_valid = 4'b0001;
        a.in_data  = {16'h0044, 16'h0033, 16'h0022, 16'h1234};
        step();
        check("bp_load", 32'(a.out_data), 32'h1234);
        a.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a.in_valid = 4'b1111;
            a.in_data  = {4{16'(16'hA000 + i)}};
            #1;
            check($sformatf("bp_ready%0d", i), 32'(a.in_ready), 0);
            step();
            check($sformatf("bp_data%0d", i), 32'(a.out_data), 32'h1234);
            check($sformatf("bp_sel%0d", i), 32'(a.out_sel), 0);
            check($sformatf("bp_valid%0d", i), 32'(a.out_valid), 1);
        end
        a.in_valid = 4'b0100;
        a.in_data  = {16'h0000, 16'h5678, 16'h0000, 16'h0000};
        a.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(a.in_ready), 32'h4);
        step();
        check("bp_release_data", 32'(a.out_data), 32'h5678);
        check("bp_release_sel", 32'(a.out_sel), 2);
        a.in_valid = '0;
        step();
        check("rr_drain_valid", 32'(a.out_valid), 0);
        b.in_valid = 4'b1010;
        b.in_data  = {16'h0B03, 16'h0000, 16'h0B01, 16'h0000};
        b.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("fp_ready%0d", i), 32'(b.in_ready), 32'h2);
            step();
            check($sformatf("fp_sel%0d", i), 32'(b.out_sel), 1);
            check($sformatf("fp_data%0d", i), 32'(b.out_data), 32'h0B01);
        end
        c.in_valid = 3'b111;
        c.in_data  = {16'h0C02, 16'h0C01, 16'h0C00};
        c.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("n3_sel%0d", i), 32'(c.out_sel), 32'(i % 3));
            check($sformatf("n3_data%0d", i), 32'(c.out_data), 32'(16'h0C00 + i % 3));
            check($sformatf("n3_ptr%0d", i), 32'(u_n3.ptr), 32'((i + 1) % 3));
        end
        c.in_valid = '0;
        step();
        check("n3_drain_valid", 32'(c.out_valid), 0);
        check("n3_drain_sel", 32'(c.out_sel), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor to the 2:1 operand mux used in the GCD datapath.
- Selects one of NUM_IN valid/ready input streams of WIDTH bits and forwards it through a single registered output stage.
- Arbitration is fixed-priority or round-robin, chosen by a parameter.
- Feeds operand/result buses in the GCD and follow-on arithmetic blocks where several producers share one consumer.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- NUM_IN, 4, number of input channels; legal range 2..16.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- SEL_W (localparam), max(1, clog2(NUM_IN)), width of the channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; channel i is in_data[i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready, one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_sel  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - On rst_n=0: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - Reset asserted mid-transfer discards the held word; nothing is replayed.
- Output register, two states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - load_en = !out_valid | out_ready.
- Arbitration (combinational):
  - Over in_valid, evaluated every cycle.
  - Fixed mode: winner is the lowest index with in_valid=1.
  - RR mode: search starts at index ptr and wraps modulo NUM_IN.
  - grant is one-hot, or zero when no input is valid.
- Ready and transfer:
  - in_ready = grant & {NUM_IN{load_en}}.
  - There is a combinational path out_ready -> in_ready; this is intended.
  - An input transfer occurs when in_valid[i] & in_ready[i].
- Register update on a clock edge with load_en=1:
  - If any grant is set: out_data <= winning channel's data, out_sel <= winner index, out_valid <= 1.
  - If no grant: out_valid <= 0, and out_data/out_sel hold their old values.
- Register update with load_en=0 (FULL and out_ready=0):
  - out_data, out_sel and out_valid hold.
  - in_ready is all zero.
  - Input data may change without effect.
- Round-robin pointer:
  - ptr <= (winner+1) mod NUM_IN only on a cycle with an input transfer.
  - Otherwise ptr holds.
  - Fixed mode ignores ptr.
- Throughput and latency:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 word/cycle when out_ready stays high.
- Simultaneous events:
  - A drain (out_valid & out_ready) and a new load in the same cycle keep out_valid=1 with the new word; no bubble.
- Wrap-around:
  - With NUM_IN not a power of two, ptr never takes values >= NUM_IN.
  - The pointer wraps from NUM_IN-1 to 0.
- Stability: out_data and out_sel are stable while out_valid=1 and out_ready=0.
- Fairness: in RR mode with all inputs continuously valid and out_ready=1, each channel is granted exactly once in every NUM_IN consecutive transfers.

Test Plan:
- Reset check: assert rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=16'h0000 and out_sel=0 immediately; after release, ptr starts at 0.
- Single channel: in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=16'hBEEF, out_sel=2.
- RR fairness: all four channels valid with data 16'h0011/22/33/44, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with matching data and no bubbles.
- Fixed priority: RR_MODE=0, in_valid=4'b1010 held for 3 cycles -> out_sel=1 every cycle; channel 3 is never granted.
- Backpressure: FULL with out_data=16'h1234, out_ready=0 for 5 cycles while inputs change -> in_ready=0, and out_data/out_sel remain unchanged; when out_ready rises, the next word loads in the same cycle.
- Non-power-of-two: NUM_IN=3, all channels valid -> out_sel cycles 0,1,2,0; ptr never reaches 3; in_valid=0 with out_ready=1 -> out_valid drops to 0 the next cycle.
